// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// Multiplies use a 32-step shift/add loop and divides a 32-step restoring
// shift/subtract loop; divide-by-zero and signed overflow finish in one cycle.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies complete in one cycle
// through a combinational 64-bit multiplier; divides stay iterative.
`timescale 1ns/1ps
module ex_muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     a_q;        // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   acc_q;      // {product hi, multiplier} or {remainder, quotient}
    logic [CW-1:0]       cnt_q;
    logic                qneg_q;     // sign of product / quotient
    logic                rneg_q;     // sign of remainder
    logic [XLEN-1:0]     result_q;

    // Two's complement when neg is set.
    function automatic logic [XLEN-1:0] cond_neg32(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg64(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? (~v + (2*XLEN)'(1)) : v;
    endfunction

    // Operand decode for the accepting cycle.
    logic            is_div, s1_sgn, s2_sgn, n1, n2;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] special_res;
    logic            fast_go;
    logic [XLEN-1:0] fast_res;

    assign is_div   = funct3_i[2];
    assign s1_sgn   = (funct3_i == 3'b001) | (funct3_i == 3'b010) |
                      (funct3_i == 3'b100) | (funct3_i == 3'b110);
    assign s2_sgn   = (funct3_i == 3'b001) | (funct3_i == 3'b100) | (funct3_i == 3'b110);
    assign n1       = s1_sgn & rs1_i[XLEN-1];
    assign n2       = s2_sgn & rs2_i[XLEN-1];
    assign mag1     = cond_neg32(rs1_i, n1);
    assign mag2     = cond_neg32(rs2_i, n2);
    assign div_zero = is_div & (rs2_i == '0);
    assign div_ovf  = is_div & ~funct3_i[0] & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_i == '1);
    assign special_res = div_zero ? (funct3_i[1] ? rs1_i : '1)
                                  : (funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

`ifdef MULDIV_FAST_MUL_EN
    // Sign-extended 64-bit operands; the low 64 bits of the product are exact.
    logic signed [2*XLEN-1:0] fa, fb, fprod;
    assign fa       = {{XLEN{n1}}, rs1_i};
    assign fb       = {{XLEN{n2}}, rs2_i};
    assign fprod    = fa * fb;
    assign fast_go  = ~is_div;
    assign fast_res = (funct3_i == 3'b000) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`else
    assign fast_go  = 1'b0;
    assign fast_res = '0;
`endif

    // One iteration of the shared multiply/divide loop.
    logic [XLEN:0]     mul_sum, rem_sh;
    logic [XLEN-1:0]   diff;
    logic              ge;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, step_nxt;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
    assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    assign ge       = rem_sh >= {1'b0, a_q};
    assign diff     = rem_sh[XLEN-1:0] - a_q;
    assign div_nxt  = ge ? {diff, acc_q[XLEN-2:0], 1'b1} : {acc_q[2*XLEN-2:0], 1'b0};
    assign step_nxt = op_q[2] ? div_nxt : mul_nxt;

    // Sign fix and result selection from the final iteration.
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res, div_res, final_res;

    assign prod      = cond_neg64(step_nxt, qneg_q);
    assign mul_res   = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    assign div_res   = op_q[1] ? cond_neg32(step_nxt[2*XLEN-1:XLEN], rneg_q)
                               : cond_neg32(step_nxt[XLEN-1:0], qneg_q);
    assign final_res = op_q[2] ? div_res : mul_res;

    logic accept, load_special, load_fast, load_final, stepping;

    // Next-state and control decode.
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        load_special = 1'b0;
        load_fast    = 1'b0;
        load_final   = 1'b0;
        stepping     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && !flush_i) begin
                    accept = 1'b1;
                    if (div_zero || div_ovf) begin
                        load_special = 1'b1;
                        state_d      = DONE;
                    end else if (fast_go) begin
                        load_fast = 1'b1;
                        state_d   = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    stepping = 1'b1;
                    if (cnt_q == CW'(ITER - 1)) begin
                        load_final = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Operand latch, iteration datapath and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            op_q   <= funct3_i;
            a_q    <= mag2;
            acc_q  <= {{XLEN{1'b0}}, mag1};
            cnt_q  <= '0;
            qneg_q <= n1 ^ n2;
            rneg_q <= n1;
            if (load_special)   result_q <= special_res;
            else if (load_fast) result_q <= fast_res;
        end else if (stepping) begin
            acc_q <= step_nxt;
            cnt_q <= cnt_q + CW'(1);
            if (load_final) result_q <= final_res;
        end
    end

    assign busy_o   = ~rst & ((state_q == CALC) | ((state_q == IDLE) & start_i));
    assign done_o   = (state_q == DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit.
`timescale 1ns/1ps
module tb_ex_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst, start_i, flush_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i, rs2_i;
    logic        busy_o, done_o;
    logic [31:0] result_o;

    int n_vec = 0;
    int n_err = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    always #5 clk = ~clk;

    ex_muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .funct3_i (funct3_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation; cycle 0 is the cycle start_i is high.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int k;
        int busy_bad;
        @(negedge clk);
        start_i = 1'b1; funct3_i = f; rs1_i = a; rs2_i = b;
        #1;
        busy_bad = (busy_o !== 1'b1) ? 1 : 0;
        @(posedge clk);
        #1;
        start_i = 1'b0; rs1_i = 32'hDEADBEEF; rs2_i = 32'h0BADF00D; funct3_i = ~f;
        k = 0;
        while (k < 80) begin
            @(negedge clk);
            k++;
            if (done_o === 1'b1) break;
            if (busy_o !== 1'b1) busy_bad++;
        end
        if (busy_o !== 1'b0) busy_bad++;
        chk({tag, "_lat"}, k, lat);
        chk({tag, "_res"}, result_o, exp);
        chk({tag, "_busy"}, busy_bad, 0);
        @(negedge clk);
        chk({tag, "_pulse"}, {31'b0, done_o}, 32'd0);
    endtask

    initial begin
        int dones;
        rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
        funct3_i = 3'b000; rs1_i = '0; rs2_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_done", {31'b0, done_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        rst = 1'b0;

        run_op("mul_7xm3",  3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
        run_op("mulh_min",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
        run_op("mulhu_max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
        run_op("mulhsu",    3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MUL_LAT);
        run_op("div_m7_2",  3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT);
        run_op("rem_m7_2",  3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT);
        run_op("div_7_m2",  3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT);
        run_op("rem_7_m2",  3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        DIV_LAT);
        run_op("divu_100_7",3'b101, 32'd100,      32'd7,        32'd14,       DIV_LAT);
        run_op("remu_100_7",3'b111, 32'd100,      32'd7,        32'd2,        DIV_LAT);
        run_op("div_by0",   3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
        run_op("remu_by0",  3'b111, 32'd5,        32'd0,        32'd5,        1);
        run_op("div_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("rem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
        run_op("mul_6x7",   3'b000, 32'd6,        32'd7,        32'd42,       MUL_LAT);

        // Flush a DIVU partway through the loop.
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'b101; rs1_i = 32'd1000; rs2_i = 32'd3;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        @(negedge clk);
        chk("flush_busy", {31'b0, busy_o}, 32'd0);
        chk("flush_done", {31'b0, done_o}, 32'd0);
        chk("flush_result", result_o, 32'd42);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o === 1'b1) dones++;
        end
        chk("flush_nodone", dones, 0);
        run_op("after_flush", 3'b101, 32'd1000, 32'd3, 32'd333, DIV_LAT);

        // Reset in the middle of the loop with start_i held high.
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'b011; rs1_i = 32'h12345678; rs2_i = 32'h9ABCDEF0;
        @(posedge clk);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_mid_done", {31'b0, done_o}, 32'd0);
        chk("rst_mid_result", result_o, 32'd0);
        rst = 1'b0;
        start_i = 1'b0;
        run_op("after_rst", 3'b000, 32'd6, 32'd7, 32'd42, MUL_LAT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
